// File: rtl/dms_lpf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dms_lpf_ctrl_pkg
// Description : Shared types for the DMS loop-filter sequencer.
//               - state_t     : sequencer state encoding (visible on state_o).
//               - lpf_flags_t : bundle of the single-bit switch controls.
//               - dec_flags() : state -> switch-control decode.
//               - CP_BOOST_RATIO : fast-lock pump current multiplier, used by
//                 the behavioural charge-pump / filter models.
// Revision    : 1.0 - initial release
// ============================================================================
package dms_lpf_ctrl_pkg;

  localparam int CP_BOOST_RATIO = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRECHG = 3'd1,
    FAST   = 3'd2,
    TRACK  = 3'd3,
    FAIL   = 3'd4
  } state_t;

  typedef struct packed {
    logic prechg_en;
    logic res_sel;
    logic cp_en;
    logic cp_boost;
    logic locked;
    logic fail;
  } lpf_flags_t;

  // Switch controls for a given state; illegal encodings decode to all-off.
  function automatic lpf_flags_t dec_flags(input state_t s);
    lpf_flags_t f;
    f = '0;
    case (s)
      PRECHG: f.prechg_en = 1'b1;
      FAST: begin
        f.res_sel  = 1'b1;
        f.cp_en    = 1'b1;
        f.cp_boost = 1'b1;
      end
      TRACK: begin
        f.cp_en  = 1'b1;
        f.locked = 1'b1;
      end
      FAIL:    f.fail = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dms_lpf_run_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dms_lpf_run_cnt
// Description : Consecutive-event counter. Counts cycles with ev=1, clears on
//               ev=0 or clr=1, saturates at LIMIT. hit is asserted in the
//               cycle whose event brings the run to LIMIT (or keeps it there),
//               so a registered consumer acts on exactly the LIMIT-th event.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               clr  - synchronous clear (counter not in use)
//               ev   - event for this cycle
//               hit  - run of LIMIT consecutive events completes this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module dms_lpf_run_cnt #(
  parameter int CNT_W = 16,
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ev,
  output logic hit
);

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !ev) begin
      cnt_d = '0;
    end else if (cnt_q != C_LIMIT) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  assign hit = ev && !clr && (cnt_q >= C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dms_lpf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dms_lpf_ctrl
// Description : Sequencer for the DMS loop filter. On start it precharges the
//               filter node, runs fast-lock (low series R, boosted pump) and,
//               once lock is qualified, drops to nominal-bandwidth tracking.
//               All outputs are registered and decoded from the next state,
//               so they always match state_o.
// Option      : DMS_LPF_CTRL_RELOCK_EN
//               defined   - loss of lock in TRACK re-enters FAST directly.
//               undefined - loss of lock in TRACK goes to FAIL.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               start        - level enable (0 aborts to IDLE)
//               lock_det     - raw lock indication
//               prechg_en    - precharge switch
//               vinit_code   - precharge DAC code
//               res_sel      - 1 = fast-lock series R
//               cp_en        - charge pump enable
//               cp_boost     - charge pump current boost
//               locked       - lock qualified (TRACK)
//               fail         - fast-lock timeout / loss of lock
//               state_o      - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module dms_lpf_ctrl
  import dms_lpf_ctrl_pkg::*;
#(
  parameter int PRECHG_CYC   = 256,
  parameter int FASTLOCK_CYC = 4096,
  parameter int LOCK_QUAL    = 64,
  parameter int LOL_CYC      = 16,
  parameter int CNT_W        = 16,
  parameter int DAC_W        = 8,
  parameter int VINIT_CODE   = 192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lock_det,
  output logic             prechg_en,
  output logic [DAC_W-1:0] vinit_code,
  output logic             res_sel,
  output logic             cp_en,
  output logic             cp_boost,
  output logic             locked,
  output logic             fail,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] C_PRE_LAST  = CNT_W'(PRECHG_CYC - 1);
  localparam logic [CNT_W-1:0] C_FAST_LAST = CNT_W'(FASTLOCK_CYC - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [DAC_W-1:0] C_VINIT     = DAC_W'(VINIT_CODE);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  lpf_flags_t       flags_q;
  logic [DAC_W-1:0] vinit_q;
  logic             qual_hit;
  logic             lol_hit;

  // Lock qualification: only live in FAST, so every FAST entry starts fresh.
  dms_lpf_run_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (LOCK_QUAL)
  ) u_qual_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q != FAST),
    .ev  (lock_det),
    .hit (qual_hit)
  );

  // Loss-of-lock detection: only live in TRACK.
  dms_lpf_run_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (LOL_CYC)
  ) u_lol_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q != TRACK),
    .ev  (!lock_det),
    .hit (lol_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = PRECHG;
      PRECHG: if (timer_q == C_PRE_LAST) state_d = FAST;
      FAST: begin
        // Qualification beats timeout when both land on the same edge.
        if (qual_hit) begin
          state_d = TRACK;
        end else if (timer_q == C_FAST_LAST) begin
          state_d = FAIL;
        end
      end
      TRACK: begin
        if (lol_hit) begin
`ifdef DMS_LPF_CTRL_RELOCK_EN
          state_d = FAST;
`else
          state_d = FAIL;
`endif
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
    // Abort has priority over everything; the filter keeps its voltage.
    if (!start) begin
      state_d = IDLE;
    end
  end

  // Elapsed-cycles-in-state timer; zero on every state entry.
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) && ((state_q == PRECHG) || (state_q == FAST))) begin
      timer_d = timer_q + C_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      flags_q <= '0;
      vinit_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      flags_q <= dec_flags(state_d);
      vinit_q <= (state_d == PRECHG) ? C_VINIT : '0;
    end
  end

  assign prechg_en  = flags_q.prechg_en;
  assign res_sel    = flags_q.res_sel;
  assign cp_en      = flags_q.cp_en;
  assign cp_boost   = flags_q.cp_boost;
  assign locked     = flags_q.locked;
  assign fail       = flags_q.fail;
  assign vinit_code = vinit_q;
  assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_dms_lpf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dms_lpf_ctrl
// Description : Directed self-checking bench for dms_lpf_ctrl with
//               PRECHG_CYC=4, FASTLOCK_CYC=32, LOCK_QUAL=4, LOL_CYC=3.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dms_lpf_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       lock_det;
  logic       prechg_en;
  logic [7:0] vinit_code;
  logic       res_sel;
  logic       cp_en;
  logic       cp_boost;
  logic       locked;
  logic       fail;
  logic [2:0] state_o;

  int n_checks;
  int n_fails;

  dms_lpf_ctrl #(
    .PRECHG_CYC   (4),
    .FASTLOCK_CYC (32),
    .LOCK_QUAL    (4),
    .LOL_CYC      (3),
    .CNT_W        (16),
    .DAC_W        (8),
    .VINIT_CODE   (192)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lock_det   (lock_det),
    .prechg_en  (prechg_en),
    .vinit_code (vinit_code),
    .res_sel    (res_sel),
    .cp_en      (cp_en),
    .cp_boost   (cp_boost),
    .locked     (locked),
    .fail       (fail),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word {prechg_en, vinit_code, res_sel, cp_en, cp_boost,
  // locked, fail, state_o} for each state, written out by hand.
  function automatic logic [31:0] exp_out(input int st);
    case (st)
      0:       return 32'h0_0000;                            // IDLE
      1:       return {15'd0, 1'b1, 8'd192, 5'b00000, 3'd1}; // PRECHG
      2:       return {15'd0, 1'b0, 8'd0,   5'b11100, 3'd2}; // FAST
      3:       return {15'd0, 1'b0, 8'd0,   5'b01010, 3'd3}; // TRACK
      4:       return {15'd0, 1'b0, 8'd0,   5'b00001, 3'd4}; // FAIL
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] act_out();
    return {15'd0, prechg_en, vinit_code, res_sel, cp_en, cp_boost, locked, fail, state_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_st(input string tag, input int st);
    chk(tag, act_out(), exp_out(st));
  endtask

  // From IDLE with start low: raise start and walk through precharge.
  // Returns on the first falling edge in FAST.
  task automatic run_to_fast(input string tag);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_st({tag, "_prechg"}, 1);
    end
    tick(1);
    chk_st({tag, "_fast_entry"}, 2);
  endtask

  task automatic abort(input string tag);
    start    = 1'b0;
    lock_det = 1'b0;
    tick(1);
    chk_st({tag, "_abort_idle"}, 0);
  endtask

  localparam logic [7:0] QPAT = 8'b1111_0111; // applied LSB first: 1,1,1,0,1,1,1,1

  initial begin
    logic [7:0] pat;
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    lock_det = 1'b0;

    // ---- reset ----
    tick(2);
    chk_st("reset_outputs", 0);
    start = 1'b1;
    tick(1);
    chk_st("reset_holds_idle", 0);
    start = 1'b0;
    rst   = 1'b0;
    tick(1);
    chk_st("post_reset_idle", 0);

    // ---- nominal lock ----
    run_to_fast("nom");
    lock_det = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_st("nom_qualifying", 2);
    end
    tick(1);
    chk_st("nom_locked", 3);

    // ---- loss of lock: two zeros then a one is harmless ----
    lock_det = 1'b0;
    tick(2);
    chk_st("lol_two_zeros", 3);
    lock_det = 1'b1;
    tick(1);
    chk_st("lol_recovered", 3);
    lock_det = 1'b0;
    tick(2);
    chk_st("lol_two_more", 3);
    tick(1);
`ifdef DMS_LPF_CTRL_RELOCK_EN
    chk_st("lol_relock_fast", 2);
`else
    chk_st("lol_to_fail", 4);
`endif
    abort("lol");

    // ---- qualification restart ----
    run_to_fast("qual");
    pat = QPAT;
    for (int i = 0; i < 8; i++) begin
      lock_det = pat[i];
      tick(1);
      chk_st("qual_step", (i == 7) ? 3 : 2);
    end
    abort("qual");

    // ---- fast-lock timeout ----
    run_to_fast("tmo");
    tick(31);
    chk_st("tmo_last_fast_cycle", 2);
    tick(1);
    chk_st("tmo_fail", 4);
    tick(3);
    chk_st("tmo_fail_held_with_start", 4);
    abort("tmo");

    // ---- abort during precharge cycle 2 ----
    start = 1'b1;
    tick(2);
    chk_st("abort_prechg_c2", 1);
    abort("prechg");

    // ---- asynchronous reset mid-FAST ----
    run_to_fast("arst");
    tick(2);
    chk_st("arst_in_fast", 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_outputs_zero", act_out(), exp_out(0));
    start = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk_st("arst_released_idle", 0);

    // ---- tie: qualification on the timeout edge ----
    run_to_fast("tie");
    tick(28);
    chk_st("tie_mid_fast", 2);
    lock_det = 1'b1;
    tick(3);
    chk_st("tie_before_limit", 2);
    tick(1);
    chk_st("tie_track_wins", 3);
    abort("tie");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
